// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, stop bit(s)
// Optional build macro: UART_TX_TWO_STOP_EN adds the Stop2 input (second stop bit per frame).
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  Stop2,
`endif
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            ps_q, ps_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;
  logic                  last_data;
  logic                  stop_last;

  // The frame snapshot keeps Prescale >= 1, so ps_q - 1 never underflows during a frame.
  assign bit_end   = (edge_cnt_q == (ps_q - 6'd1));
  assign last_data = (bit_cnt_q == BW'(DATA_WIDTH - 1));

`ifdef UART_TX_TWO_STOP_EN
  logic stop2_q, stop2_d;

  // Stop-bit count setting is part of the frame snapshot.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stop2_q <= 1'b0;
    else      stop2_q <= stop2_d;
  end

  // Latch Stop2 only when a new frame is accepted.
  always_comb begin
    stop2_d = stop2_q;
    if (state_q == IDLE && Data_Valid) stop2_d = Stop2;
  end

  // bit_cnt counts stop bits while in STOP.
  assign stop_last = (bit_cnt_q == {{(BW-1){1'b0}}, stop2_q});
`else
  assign stop_last = 1'b1;
`endif

  // State, counters, frame snapshot and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      ps_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      ps_q       <= ps_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, counter sequencing and line value derived from the current state.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    ps_d       = ps_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (Data_Valid) begin
          shift_d   = P_DATA;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          ps_d      = (Prescale == 6'd0) ? 6'd1 : Prescale;
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (last_data) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        // Parity comes from the latched word; the shifter has been emptied by now.
        tx_d = (^data_q) ^ par_typ_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_last) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd1;
`ifdef UART_TX_TWO_STOP_EN
  logic       Stop2 = 1'b0;
`endif
  logic       TX_OUT;
  logic       Busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t sb[$];

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
`ifdef UART_TX_TWO_STOP_EN
    .Stop2      (Stop2),
`endif
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample 1 time unit after the edge and compare with the scoreboard head (idle if empty).
  task automatic tick(input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.tx   = 1'b1;
      e.busy = 1'b0;
    end
    check({tag, "_tx"}, TX_OUT, e.tx);
    check({tag, "_busy"}, Busy, e.busy);
  endtask

  task automatic push_bit(input logic v, input int n);
    exp_t e;
    e.tx   = v;
    e.busy = 1'b1;
    repeat (n) sb.push_back(e);
  endtask

  // Expected line per cycle: one idle cycle of latency, then the frame.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps, input logic s2);
    exp_t idle;
    int   eff;
    idle.tx   = 1'b1;
    idle.busy = 1'b0;
    sb.push_back(idle);
    eff = (ps == 6'd0) ? 1 : int'(ps);
    push_bit(1'b0, eff);
    for (int i = 0; i < 8; i++) push_bit(d[i], eff);
    if (pe) push_bit((d[0]^d[1]^d[2]^d[3]^d[4]^d[5]^d[6]^d[7]) ^ pt, eff);
    push_bit(1'b1, (s2 ? 2 : 1) * eff);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps, input logic s2);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
`ifdef UART_TX_TWO_STOP_EN
    Stop2      = s2;
`endif
    Data_Valid = 1'b1;
    push_frame(d, pe, pt, ps, s2);
    tick(tag);
    Data_Valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int extra);
    while (sb.size() > 0) tick(tag);
    repeat (extra) tick({tag, "_idle"});
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge.
    #2 RST = 1'b0;
    #1;
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);
    tick("reset_hold");
    RST = 1'b1;
    tick("post_reset");

    // Basic frame, no parity: 0xA5 at Prescale=8 -> 80 busy cycles.
    send("basic", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    drain("basic", 2);

    // Even and odd parity on 0x07 at Prescale=4 -> 44 busy cycles each.
    send("par_even", 8'h07, 1'b1, 1'b0, 6'd4, 1'b0);
    drain("par_even", 1);
    send("par_odd", 8'h07, 1'b1, 1'b1, 6'd4, 1'b0);
    drain("par_odd", 1);

    // Strobe and setting changes mid-frame must not disturb the frame or queue another.
    send("ignore", 8'h96, 1'b1, 1'b0, 6'd3, 1'b0);
    repeat (5) tick("ignore");
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    Prescale   = 6'd1;
    Data_Valid = 1'b1;
    tick("ignore_strobe");
    Data_Valid = 1'b0;
    repeat (3) tick("ignore");
    PAR_EN   = 1'b1;
    Prescale = 6'd9;
    drain("ignore", 6);

    // Back-to-back at Prescale=1: accepted in the first idle cycle, gap of stop + 1 idle.
    send("b2b_a", 8'h3C, 1'b0, 1'b0, 6'd1, 1'b0);
    drain("b2b_a", 0);
    send("b2b_b", 8'hC3, 1'b0, 1'b0, 6'd1, 1'b0);
    drain("b2b_b", 0);

    // Prescale=0 must behave exactly like Prescale=1.
    send("ps0_a", 8'h3C, 1'b0, 1'b0, 6'd0, 1'b0);
    drain("ps0_a", 0);
    send("ps0_b", 8'h81, 1'b1, 1'b1, 6'd0, 1'b0);
    drain("ps0_b", 2);

    // Reset mid-frame during DATA, then a clean frame after release.
    send("mid_rst", 8'hA5, 1'b0, 1'b0, 6'd4, 1'b0);
    repeat (12) tick("mid_rst");
    #2 RST = 1'b0;
    #1;
    check("mid_rst_async_tx", TX_OUT, 1'b1);
    check("mid_rst_async_busy", Busy, 1'b0);
    sb.delete();
    repeat (2) tick("mid_rst_hold");
    RST = 1'b1;
    tick("mid_rst_release");
    send("after_rst", 8'hA5, 1'b0, 1'b0, 6'd4, 1'b0);
    drain("after_rst", 2);

`ifdef UART_TX_TWO_STOP_EN
    // Two stop bits at Prescale=16 -> 32 stop cycles, 176 busy cycles.
    send("stop2", 8'h55, 1'b0, 1'b0, 6'd16, 1'b1);
    drain("stop2", 2);
    send("stop1", 8'h0F, 1'b1, 1'b0, 6'd2, 1'b0);
    drain("stop1", 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
